// File: rtl/alu_button_ctrl_if.sv
// Board-side bundle for alu_button_ctrl: enable, switch bus, raw buttons and the result outputs.
// The design drives through the slave modport; the board or bench uses the master modport.
interface alu_button_ctrl_if #(
  parameter int unsigned NB_DATA = 8
);
  logic               i_enable;
  logic [NB_DATA-1:0] i_data;
  logic               i_A_button;
  logic               i_B_button;
  logic               i_OP_button;
  logic [NB_DATA-1:0] o_result;
  logic               o_valid;
  logic               o_err;
  logic [2:0]         o_flags;

  modport master (
    output i_enable, i_data, i_A_button, i_B_button, i_OP_button,
    input  o_result, o_valid, o_err, o_flags
  );

  modport slave (
    input  i_enable, i_data, i_A_button, i_B_button, i_OP_button,
    output o_result, o_valid, o_err, o_flags
  );
endinterface

// File: rtl/alu_button_ctrl.sv
// Debounced button loader for A/B/opcode plus a registered ALU with valid pulse and error flag.
// Define ALU_FLAGS_EN to build the {overflow, carry, zero} flag logic; otherwise o_flags is 0.
module alu_button_ctrl #(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_OP           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic              i_clk,
  input logic              i_reset,
  alu_button_ctrl_if.slave bus
);
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned Msb = NB_DATA - 1;

  localparam logic [NB_OP-1:0] OpAdd = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OpSub = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OpAnd = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OpOr  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OpXor = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OpSra = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OpSrl = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OpNor = NB_OP'(6'b100111);

  // Button index: 0 = A, 1 = B, 2 = OP.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q, level_q, prev_q;
  logic [CntW-1:0] cnt_q [3];
  logic [2:0]      load;

  assign btn_raw = {bus.i_OP_button, bus.i_B_button, bus.i_A_button};
  assign load    = {3{bus.i_enable}} & level_q & ~prev_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (!bus.i_enable) begin
          // Force high so a button still held when enable returns cannot make an edge.
          cnt_q[i]   <= '0;
          level_q[i] <= 1'b1;
          prev_q[i]  <= 1'b1;
        end else begin
          prev_q[i] <= level_q[i];
          if (sync2_q[i] == level_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CntLast) begin
            level_q[i] <= sync2_q[i];
            cnt_q[i]   <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  logic [NB_DATA-1:0] a_q, b_q, result_q, alu_res;
  logic [NB_OP-1:0]   op_q;
  logic [2:0]         loaded_q;
  logic               calc_q, valid_q, err_q, alu_err;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      OpAdd:   alu_res = a_q + b_q;
      OpSub:   alu_res = a_q - b_q;
      OpAnd:   alu_res = a_q & b_q;
      OpOr:    alu_res = a_q | b_q;
      OpXor:   alu_res = a_q ^ b_q;
      OpNor:   alu_res = ~(a_q | b_q);
      OpSra:   alu_res = $signed(a_q) >>> b_q;
      OpSrl:   alu_res = a_q >> b_q;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      loaded_q <= '0;
      calc_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (load[0]) a_q  <= bus.i_data;
      if (load[1]) b_q  <= bus.i_data;
      if (load[2]) op_q <= bus.i_data[NB_OP-1:0];
      loaded_q <= loaded_q | load;
      calc_q   <= |load;
      valid_q  <= 1'b0;
      // Recompute one edge after the load, once every field has been seen.
      if (calc_q && (&loaded_q)) begin
        result_q <= alu_res;
        err_q    <= alu_err;
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.o_result = result_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_err    = err_q;

`ifdef ALU_FLAGS_EN
  logic [2:0] flags_d, flags_q;

  // Carry out of an add shows as the wrapped sum falling below A; borrow is A < B.
  always_comb begin
    flags_d = {2'b00, (alu_res == '0)};
    if (op_q == OpAdd) begin
      flags_d[1] = (alu_res < a_q);
      flags_d[2] = (a_q[Msb] == b_q[Msb]) && (alu_res[Msb] != a_q[Msb]);
    end else if (op_q == OpSub) begin
      flags_d[1] = (a_q < b_q);
      flags_d[2] = (a_q[Msb] != b_q[Msb]) && (alu_res[Msb] != a_q[Msb]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      flags_q <= '0;
    end else if (calc_q && (&loaded_q)) begin
      flags_q <= flags_d;
    end
  end

  assign bus.o_flags = flags_q;
`else
  assign bus.o_flags = 3'b000;
`endif
endmodule

// File: tb/tb_alu_button_ctrl.sv
// Self-checking bench for alu_button_ctrl: directed scenarios then random presses against
// an arithmetic reference model of the loaded fields and ALU.
module tb_alu_button_ctrl;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   last_valid_cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  int m_a = 0, m_b = 0, m_op = 0;
  bit m_la = 0, m_lb = 0, m_lop = 0;

  alu_button_ctrl_if #(.NB_DATA(8)) bus ();

  alu_button_ctrl #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int res, output int err, output int flags);
    int sa, sb, s, ovf, cy;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    err = 0;
    ovf = 0;
    cy  = 0;
    res = 0;
    case (op)
      'h20: begin
        res = (a + b) % 256;
        cy  = (a + b >= 256) ? 1 : 0;
        s   = sa + sb;
        ovf = (s > 127 || s < -128) ? 1 : 0;
      end
      'h22: begin
        res = (a - b + 256) % 256;
        cy  = (a < b) ? 1 : 0;
        s   = sa - sb;
        ovf = (s > 127 || s < -128) ? 1 : 0;
      end
      'h24: res = a & b;
      'h25: res = a | b;
      'h26: res = a ^ b;
      'h27: res = 255 - (a | b);
      'h03: res = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
      'h02: res = (b >= 8) ? 0 : (a >> b);
      default: err = 1;
    endcase
`ifdef ALU_FLAGS_EN
    flags = ovf * 4 + cy * 2 + ((res == 0) ? 1 : 0);
`else
    flags = 0;
`endif
  endfunction

  task automatic release_buttons();
    bus.i_A_button  = 1'b0;
    bus.i_B_button  = 1'b0;
    bus.i_OP_button = 1'b0;
  endtask

  // Clean press of the masked buttons; 'takes' says whether the model expects it to load.
  task automatic do_press(input logic [2:0] mask, input logic [7:0] data, input int hold,
                          input bit takes);
    int v0, pc, r, e, f;
    bit all;
    @(posedge clk);
    #1;
    bus.i_data      = data;
    bus.i_A_button  = mask[0];
    bus.i_B_button  = mask[1];
    bus.i_OP_button = mask[2];
    v0 = valid_cnt;
    pc = cyc;
    repeat (hold) @(posedge clk);
    #1;
    release_buttons();
    repeat (D + 8) @(posedge clk);
    #1;
    if (takes) begin
      if (mask[0]) begin m_a = int'(data); m_la = 1; end
      if (mask[1]) begin m_b = int'(data); m_lb = 1; end
      if (mask[2]) begin m_op = int'(data) % 64; m_lop = 1; end
    end
    all = m_la && m_lb && m_lop;
    check("valid_count", 32'(valid_cnt - v0), (takes && all) ? 1 : 0);
    if (takes && all) begin
      check("valid_latency", 32'(last_valid_cyc - pc), D + 4);
      alu_ref(m_op, m_a, m_b, r, e, f);
      check("result", 32'(bus.o_result), r);
      check("err", 32'(bus.o_err), e);
      check("flags", 32'(bus.o_flags), f);
    end else if (!all) begin
      check("result_idle", 32'(bus.o_result), 0);
    end
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_result"}, 32'(bus.o_result), 0);
    check({tag, "_valid"}, 32'(bus.o_valid), 0);
    check({tag, "_err"}, 32'(bus.o_err), 0);
    check({tag, "_flags"}, 32'(bus.o_flags), 0);
  endtask

  initial begin
    int v0;
    int ops [8] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h03, 'h02, 'h27};
    logic [2:0] mask;
    logic [7:0] data;

    bus.i_enable = 1'b1;
    bus.i_data   = '0;
    release_buttons();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_clear("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Scenario 1: 0x7F + 0x01 signed overflow.
    do_press(3'b001, 8'h7F, 10, 1);
    do_press(3'b010, 8'h01, 10, 1);
    do_press(3'b100, 8'h20, 10, 1);

    // Scenario 2: SUB borrow, then shifts.
    do_press(3'b001, 8'h00, 10, 1);
    do_press(3'b100, 8'h22, 10, 1);
    do_press(3'b001, 8'h80, 10, 1);
    do_press(3'b010, 8'h03, 10, 1);
    do_press(3'b100, 8'h03, 10, 1);
    do_press(3'b100, 8'h02, 10, 1);
    do_press(3'b100, 8'h03, 10, 1);
    do_press(3'b010, 8'h09, 10, 1);

    // Scenario 3: short glitch ignored, long hold loads once.
    do_press(3'b001, 8'h55, 3, 0);
    do_press(3'b010, 8'h01, 10, 1);
    do_press(3'b001, 8'hC4, 50, 1);

    // Scenario 4: unsupported opcode, then NOR clears the error.
    do_press(3'b100, 8'h3F, 10, 1);
    do_press(3'b001, 8'h0F, 10, 1);
    do_press(3'b010, 8'h0F, 10, 1);
    do_press(3'b100, 8'h27, 10, 1);

    // Scenario 5a: press while disabled, and press held across enable rising.
    @(posedge clk);
    #1;
    bus.i_enable = 1'b0;
    do_press(3'b001, 8'h99, 10, 0);
    @(posedge clk);
    #1;
    v0 = valid_cnt;
    bus.i_data = 8'hAA;
    bus.i_A_button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.i_enable = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    release_buttons();
    repeat (D + 8) @(posedge clk);
    #1;
    check("enable_rise_held", 32'(valid_cnt - v0), 0);
    do_press(3'b010, 8'h10, 10, 1);

    // Scenario 5b: reset in the middle of a debounce.
    @(posedge clk);
    #1;
    v0 = valid_cnt;
    bus.i_data = 8'h33;
    bus.i_A_button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    release_buttons();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_clear("mid_reset");
    rst_n = 1'b1;
    m_la = 0; m_lb = 0; m_lop = 0;
    m_a = 0; m_b = 0; m_op = 0;
    repeat (D + 10) @(posedge clk);
    #1;
    check("post_reset_no_valid", 32'(valid_cnt - v0), 0);
    do_press(3'b010, 8'h05, 10, 1);

    // Scenario 6: A and OP together with 0x20.
    do_press(3'b101, 8'h20, 10, 1);

    // Random presses, including simultaneous buttons and occasional bad opcodes.
    for (int i = 0; i < 20; i++) begin
      mask = 3'($urandom_range(1, 7));
      data = 8'($urandom_range(0, 255));
      if (mask[2]) begin
        if ($urandom_range(0, 7) == 0) data[5:0] = 6'($urandom_range(0, 63));
        else data[5:0] = 6'(ops[$urandom_range(0, 7)]);
      end
      do_press(mask, data, 10, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
